// File: rtl/bm_down_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bm_down_counter_if                                        |
// | Desc     : Decrement/load/count bundle for the base-BASE down counter|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface bm_down_counter_if #(
    parameter int BASE   = 10,
    parameter int DIGITS = 2
);
    localparam int W = (BASE > 2) ? $clog2(BASE) : 1;

    logic                ei;
    logic                load;
    logic [DIGITS*W-1:0] din;
    logic [DIGITS*W-1:0] q;
    logic                eu;
    logic                zero;

    modport master (output ei, load, din, input  q, eu, zero);
    modport slave  (input  ei, load, din, output q, eu, zero);
endinterface
`default_nettype wire

// File: rtl/bm_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bm_down_counter                                           |
// | Desc     : DIGITS-digit base-BASE down counter with borrow chain,    |
// |            clamped parallel load and zero flag                       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module bm_down_counter #(
    parameter int BASE   = 10,
    parameter int DIGITS = 2
) (
    input  wire logic         clock,
    input  wire logic         reset,
    bm_down_counter_if.slave  bus
);
    localparam int W = (BASE > 2) ? $clog2(BASE) : 1;
    localparam logic [W-1:0] C_DIGIT_MAX = W'(BASE - 1);

    if (BASE < 2) begin : g_bad_base
        $error("bm_down_counter: BASE must be at least 2");
    end
    if (DIGITS < 1) begin : g_bad_digits
        $error("bm_down_counter: DIGITS must be at least 1");
    end

    logic [DIGITS*W-1:0] r_q;
    logic [DIGITS*W-1:0] w_load_val;
    logic [DIGITS*W-1:0] w_dec_val;
    // w_chain[i] is high when every digit below i is zero, i.e. digit i steps
    logic [DIGITS:0]     w_chain;

    assign w_chain[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [W-1:0] w_cur;
        logic [W-1:0] w_in;

        assign w_cur = r_q[i*W +: W];
        assign w_in  = bus.din[i*W +: W];

        assign w_chain[i+1] = w_chain[i] & (w_cur == '0);

        // Out-of-range load digits saturate so the count never leaves 0..BASE-1
        assign w_load_val[i*W +: W] = (w_in > C_DIGIT_MAX) ? C_DIGIT_MAX : w_in;

        assign w_dec_val[i*W +: W] = !w_chain[i]    ? w_cur :
                                     (w_cur == '0)  ? C_DIGIT_MAX :
                                                      w_cur - W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else if (bus.load) begin
            r_q <= w_load_val;
        end else if (bus.ei) begin
            r_q <= w_dec_val;
        end
    end

    assign bus.q    = r_q;
    assign bus.zero = w_chain[DIGITS];
    assign bus.eu   = bus.ei & ~bus.load & ~reset & w_chain[DIGITS];
endmodule
`default_nettype wire

// File: tb/tb_bm_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bm_down_counter                                        |
// | Desc     : Scoreboard bench for a decimal 2-digit and a binary       |
// |            1-digit down counter against an integer reference model   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_bm_down_counter;
    localparam int B1  = 10;
    localparam int D1  = 2;
    localparam int W1  = 4;
    localparam int DW1 = D1 * W1;
    localparam int M1  = 100;   // B1**D1
    localparam int B2  = 2;
    localparam int D2  = 1;
    localparam int W2  = 1;
    localparam int DW2 = D2 * W2;
    localparam int M2  = 2;

    typedef struct {
        logic [31:0] q;
        logic        zero;
        logic        eu;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   v1    = 0;
    int   v2    = 0;
    exp_t sb1[$];
    exp_t sb2[$];
    exp_t x1;
    exp_t x2;

    bm_down_counter_if #(.BASE(B1), .DIGITS(D1)) bus1 ();
    bm_down_counter_if #(.BASE(B2), .DIGITS(D2)) bus2 ();

    bm_down_counter #(.BASE(B1), .DIGITS(D1)) u_dut1 (
        .clock (clk),
        .reset (rst),
        .bus   (bus1.slave)
    );

    bm_down_counter #(.BASE(B2), .DIGITS(D2)) u_dut2 (
        .clock (clk),
        .reset (rst),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count value -> packed digit vector
    function automatic logic [31:0] enc(input int v, input int base, input int digits, input int w);
        logic [31:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < digits; i++) begin
            r = r | (32'(t % base) << (i * w));
            t = t / base;
        end
        return r;
    endfunction

    // Packed load vector -> count value, each digit saturated at base-1
    function automatic int ld(input logic [31:0] d, input int base, input int digits, input int w);
        int v;
        int pw;
        int dig;
        v  = 0;
        pw = 1;
        for (int i = 0; i < digits; i++) begin
            dig = int'((d >> (i * w)) & ((32'd1 << w) - 32'd1));
            if (dig > base - 1) dig = base - 1;
            v  = v + dig * pw;
            pw = pw * base;
        end
        return v;
    endfunction

    function automatic int nxt(input int v, input logic r, input logic l, input logic e,
                               input logic [31:0] d, input int base, input int digits,
                               input int w, input int m);
        if (r)      return 0;
        else if (l) return ld(d, base, digits, w);
        else if (e) return (v == 0) ? m - 1 : v - 1;
        else        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs to both counters and queue the visible response
    task automatic step(input logic r, input logic l, input logic e,
                        input logic [31:0] d, input logic d2);
        exp_t a;
        exp_t b;
        rst       = r;
        bus1.load = l;
        bus1.ei   = e;
        bus1.din  = d[DW1-1:0];
        bus2.load = l;
        bus2.ei   = e;
        bus2.din  = d2;
        a.q    = enc(v1, B1, D1, W1);
        a.zero = (v1 == 0);
        a.eu   = e & ~l & ~r & (v1 == 0);
        b.q    = enc(v2, B2, D2, W2);
        b.zero = (v2 == 0);
        b.eu   = e & ~l & ~r & (v2 == 0);
        sb1.push_back(a);
        sb2.push_back(b);
        v1 = nxt(v1, r, l, e, d, B1, D1, W1, M1);
        v2 = nxt(v2, r, l, e, {31'd0, d2}, B2, D2, W2, M2);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb1.size() > 0) begin
            x1 = sb1.pop_front();
            chk("q_dec",    32'(bus1.q),    x1.q);
            chk("zero_dec", 32'(bus1.zero), 32'(x1.zero));
            chk("eu_dec",   32'(bus1.eu),   32'(x1.eu));
        end
        if (sb2.size() > 0) begin
            x2 = sb2.pop_front();
            chk("q_bin",    32'(bus2.q),    x2.q);
            chk("zero_bin", 32'(bus2.zero), 32'(x2.zero));
            chk("eu_bin",   32'(bus2.eu),   32'(x2.eu));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst       = 1'b1;
        bus1.ei   = 1'b1;
        bus1.load = 1'b1;
        bus1.din  = 8'h37;
        bus2.ei   = 1'b1;
        bus2.load = 1'b1;
        bus2.din  = 1'b1;
        @(posedge clk);
        #1;
        v1 = 0;
        v2 = 0;

        // Reset held with load and ei asserted
        step(1'b1, 1'b1, 1'b1, 32'h37, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h37, 1'b1);

        // Wrap from 00 then a full countdown back through 00 to 99
        step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);

        // Load ignores ei, then holds
        step(1'b0, 1'b1, 1'b1, 32'h42, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Clamped load, short countdown, reset mid-count
        step(1'b0, 1'b1, 1'b0, 32'hCF, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Randomised mix of reset, load, decrement and hold
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), $urandom, 1'($urandom));
        end

        @(negedge clk);
        #1;
        chk("drain_dec", 32'(sb1.size()), 32'd0);
        chk("drain_bin", 32'(sb2.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
